// File: rtl/mfcc_delta_ctrl_if.sv
// Handshake and strobe bundle between the delta sequencer, the DCT producer,
// the delta datapath and the feature store.
interface mfcc_delta_ctrl_if;
  logic        frame_valid;
  logic        frame_ready;
  logic        flush;
  logic [1:0]  wr_slot;
  logic [6:0]  regc_addr;
  logic        delta_en;
  logic        delta_new;
  logic        delta_sub;
  logic        delta_shift;
  logic [12:0] regcep_addr;
  logic        regcep_wren;
  logic [7:0]  framenum;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    input  frame_valid, flush,
    output frame_ready, wr_slot, regc_addr, delta_en, delta_new, delta_sub,
           delta_shift, regcep_addr, regcep_wren, framenum, busy, done, overflow
  );

  modport slave (
    output frame_valid, flush,
    input  frame_ready, wr_slot, regc_addr, delta_en, delta_new, delta_sub,
           delta_shift, regcep_addr, regcep_wren, framenum, busy, done, overflow
  );
endinterface

// File: rtl/mfcc_delta_ctrl.sv
// MFCC delta-cepstrum sequencer over a 3-slot regc ring; edge frames replicate neighbours.
// Define DELTA_STATIC_COPY_EN to also copy the static cepstrum beside each delta.
module mfcc_delta_ctrl #(
  parameter int NCOEF = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  mfcc_delta_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_RDP, S_RDM, S_SUB, S_SHF, S_WR
`ifdef DELTA_STATIC_COPY_EN
    , S_RDC, S_CPY, S_WRS
`endif
  } state_e;

  localparam logic [3:0] K_LAST = 4'(NCOEF - 1);

  function automatic logic [1:0] inc3(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  t_q, t_d;
  logic [1:0]  slot_t_q, slot_t_d;
  logic [1:0]  plus_q, plus_d;
  logic [1:0]  minus_q, minus_d;
  logic [7:0]  framenum_q, framenum_d;
  logic [1:0]  wr_slot_q, wr_slot_d;
  logic        flushed_q, flushed_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;

  logic frame_ready;
  logic accept;
  logic have_next;
  logic last_frame;
  logic coef_done;

  assign frame_ready = (state_q == S_IDLE) && !flushed_q;
  assign accept      = bus.frame_valid && frame_ready;
  assign have_next   = {1'b0, framenum_q} >= ({1'b0, t_q} + 9'd2);
  assign last_frame  = ({1'b0, t_q} + 9'd1) == {1'b0, framenum_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      t_q        <= '0;
      slot_t_q   <= '0;
      plus_q     <= '0;
      minus_q    <= '0;
      framenum_q <= '0;
      wr_slot_q  <= '0;
      flushed_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      t_q        <= t_d;
      slot_t_q   <= slot_t_d;
      plus_q     <= plus_d;
      minus_q    <= minus_d;
      framenum_q <= framenum_d;
      wr_slot_q  <= wr_slot_d;
      flushed_q  <= flushed_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    t_d        = t_q;
    slot_t_d   = slot_t_q;
    plus_d     = plus_q;
    minus_d    = minus_q;
    framenum_d = framenum_q;
    wr_slot_d  = wr_slot_q;
    flushed_d  = flushed_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    coef_done  = 1'b0;

    // A frame arriving with the counter saturated is dropped, not queued.
    if (accept) begin
      if (framenum_q == 8'd255) begin
        overflow_d = 1'b1;
      end else begin
        framenum_d = framenum_q + 8'd1;
        wr_slot_d  = inc3(wr_slot_q);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.flush && framenum_q != 8'd0) flushed_d = 1'b1;
        if (have_next || ((bus.flush || flushed_q) && framenum_q != 8'd0)) begin
          // Without a successor frame the plus operand replicates frame t.
          plus_d  = have_next ? inc3(slot_t_q) : slot_t_q;
          minus_d = (t_q == 8'd0) ? slot_t_q : dec3(slot_t_q);
          k_d     = '0;
          state_d = S_RDP;
        end else if (bus.flush) begin
          done_d = 1'b1;
        end
      end
      S_RDP: state_d = S_RDM;
      S_RDM: state_d = S_SUB;
      S_SUB: state_d = S_SHF;
      S_SHF: state_d = S_WR;
      S_WR: begin
`ifdef DELTA_STATIC_COPY_EN
        state_d = S_RDC;
`else
        coef_done = 1'b1;
`endif
      end
`ifdef DELTA_STATIC_COPY_EN
      S_RDC: state_d = S_CPY;
      S_CPY: state_d = S_WRS;
      S_WRS: coef_done = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

    if (coef_done) begin
      if (k_q == K_LAST) begin
        state_d  = S_IDLE;
        t_d      = t_q + 8'd1;
        slot_t_d = inc3(slot_t_q);
        // Last flushed frame written: rearm for the next utterance.
        if (flushed_q && last_frame) begin
          done_d     = 1'b1;
          flushed_d  = 1'b0;
          framenum_d = '0;
          wr_slot_d  = '0;
          t_d        = '0;
          slot_t_d   = '0;
        end
      end else begin
        k_d     = k_q + 4'd1;
        state_d = S_RDP;
      end
    end
  end

  always_comb begin
    bus.regc_addr   = '0;
    bus.delta_en    = 1'b0;
    bus.delta_new   = 1'b0;
    bus.delta_sub   = 1'b0;
    bus.delta_shift = 1'b0;
    bus.regcep_addr = '0;
    bus.regcep_wren = 1'b0;
    case (state_q)
      S_RDP: bus.regc_addr = {1'b0, plus_q, k_q};
      S_RDM: begin
        bus.regc_addr = {1'b0, minus_q, k_q};
        bus.delta_en  = 1'b1;
        bus.delta_new = 1'b1;
      end
      S_SUB: begin
        bus.delta_en  = 1'b1;
        bus.delta_sub = 1'b1;
      end
      S_SHF: begin
        bus.delta_en    = 1'b1;
        bus.delta_shift = 1'b1;
      end
      S_WR: begin
        bus.regcep_wren = 1'b1;
        bus.regcep_addr = {t_q, 1'b1, k_q};
      end
`ifdef DELTA_STATIC_COPY_EN
      S_RDC: bus.regc_addr = {1'b0, slot_t_q, k_q};
      S_CPY: begin
        bus.delta_en  = 1'b1;
        bus.delta_new = 1'b1;
      end
      S_WRS: begin
        bus.regcep_wren = 1'b1;
        bus.regcep_addr = {t_q, 1'b0, k_q};
      end
`endif
      default: ;
    endcase
  end

  assign bus.frame_ready = frame_ready;
  assign bus.wr_slot     = wr_slot_q;
  assign bus.framenum    = framenum_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

endmodule
